// File: rtl/clock_pkg.sv
// Shared types and default timing constants for the time-of-day clock controller.
package clock_pkg;

  localparam logic [1:0] MODE_RUN     = 2'd0;
  localparam logic [1:0] MODE_SET_HR  = 2'd1;
  localparam logic [1:0] MODE_SET_MIN = 2'd2;

  typedef enum logic [1:0] {
    RUN     = MODE_RUN,
    SET_HR  = MODE_SET_HR,
    SET_MIN = MODE_SET_MIN
  } mode_t;

  // Defaults assume an 8 Hz and a 1 Hz tick.
  localparam int REPEAT_DLY_DEF  = 8;   // 1 s hold before auto-repeat
  localparam int REPEAT_RATE_DEF = 2;   // 4 Hz repeat
  localparam int BLINK_HALF_DEF  = 4;   // 1 Hz blink
  localparam int TIMEOUT_DEF     = 30;  // idle seconds before leaving a set mode

  // Mode button sequence: RUN -> SET_HR -> SET_MIN -> RUN.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUN:     next_mode = SET_HR;
      SET_HR:  next_mode = SET_MIN;
      default: next_mode = RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_btn_repeat.sv
// Rising-edge detect plus hold-to-repeat for a debounced button level.
// One pulse on press, then after REPEAT_DLY ticks held one pulse every
// REPEAT_RATE ticks. The pulse output is registered and one cycle wide.
module btn_repeat #(
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic tick,
  input  logic clear,
  output logic btn_edge,
  output logic pulse
);

  localparam int CW = $clog2(REPEAT_DLY + REPEAT_RATE + 1);

  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          held;
  logic          fire;

  assign btn_edge = btn & ~prev_q;
  // Counting only starts once the press has been seen for a full cycle.
  assign held     = btn & prev_q;
  assign pulse    = pulse_q;

  // Repeat counter: after the first repeat it loops between DLY and DLY+RATE.
  always_comb begin
    prev_d = btn;
    cnt_d  = cnt_q;
    fire   = 1'b0;
    if (clear || !btn) begin
      cnt_d = '0;
    end else if (held && tick) begin
      if (cnt_q == CW'(REPEAT_DLY + REPEAT_RATE - 1)) begin
        cnt_d = CW'(REPEAT_DLY);
        fire  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(REPEAT_DLY - 1)) fire = 1'b1;
      end
    end
    pulse_d = ~clear & (btn_edge | fire);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode/enable controller for the 12-hour HH:MM:SS clock chain.
// Routes the 1 Hz tick and carries in RUN, drives single-step and repeat
// increments into the selected field in the set modes, and blinks that field.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int REPEAT_DLY  = REPEAT_DLY_DEF,
  parameter int REPEAT_RATE = REPEAT_RATE_DEF,
  parameter int BLINK_HALF  = BLINK_HALF_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_8hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_cy,
  input  logic       min_cy,
  output logic       sec_enb,
  output logic       min_enb,
  output logic       hr_enb,
  output logic       sec_clr,
  output logic       blank_hr,
  output logic       blank_min,
  output logic [1:0] mode
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  mode_t         mode_q, mode_d;
  logic          mode_prev_q, mode_prev_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          sec_clr_q, sec_clr_d;

  logic mode_edge;
  logic inc_edge;
  logic inc_pulse;
  logic in_set;
  logic timeout_hit;
  logic mode_chg;
  logic rep_clear;

  assign mode_edge = btn_mode & ~mode_prev_q;
  assign in_set    = (mode_q != RUN);
  // The timeout fires on the tick that would bring the count to TIMEOUT.
  assign timeout_hit = in_set & tick_1hz & (timeout_q == TW'(TIMEOUT - 1));
  assign mode_chg  = (mode_d != mode_q);
  // Holding the repeat logic clear in RUN keeps btn_inc fully ignored there,
  // and clearing on a mode change drops an inc edge that coincides with it.
  assign rep_clear = mode_chg | ~in_set;

  btn_repeat #(
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_inc (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn_inc),
    .tick     (tick_8hz),
    .clear    (rep_clear),
    .btn_edge (inc_edge),
    .pulse    (inc_pulse)
  );

  // Mode FSM: a timeout outranks the mode button so both land in RUN.
  always_comb begin
    mode_prev_d = btn_mode;
    mode_d      = mode_q;
    if (timeout_hit) begin
      mode_d = RUN;
    end else if (mode_edge) begin
      mode_d = next_mode(mode_q);
    end
    sec_clr_d = (mode_q == SET_MIN) && (mode_d == RUN);
  end

  // Idle timeout: restarted by any button edge or mode change.
  always_comb begin
    timeout_d = timeout_q;
    if (mode_chg || mode_edge || inc_edge) begin
      timeout_d = '0;
    end else if (in_set && tick_1hz) begin
      timeout_d = timeout_q + TW'(1);
    end
  end

  // Blink phase: toggles every BLINK_HALF 8 Hz ticks, restarts dark-free on mode change.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (mode_chg) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (in_set && tick_8hz) begin
      if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= RUN;
      mode_prev_q <= 1'b0;
      timeout_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      sec_clr_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      mode_prev_q <= mode_prev_d;
      timeout_q   <= timeout_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      sec_clr_q   <= sec_clr_d;
    end
  end

  // Enable muxing: RUN passes the tick and carries straight through.
  always_comb begin
    sec_enb = 1'b0;
    min_enb = 1'b0;
    hr_enb  = 1'b0;
    if (!rst) begin
      case (mode_q)
        RUN: begin
          sec_enb = tick_1hz;
          min_enb = sec_cy;
          hr_enb  = min_cy;
        end
        SET_HR:  hr_enb  = inc_pulse;
        SET_MIN: min_enb = inc_pulse;
        default: ;
      endcase
    end
  end

  assign sec_clr   = sec_clr_q;
  assign blank_hr  = (mode_q == SET_HR)  & phase_q & ~btn_inc;
  assign blank_min = (mode_q == SET_MIN) & phase_q & ~btn_inc;
  assign mode      = mode_q;

endmodule
